// File: rtl/tile_ram_arbiter_if.sv
// rtl/tile_ram_arbiter_if.sv - display/write-requester bundle for the tile RAM arbiter
//
// Signals (slave = arbiter side):
//   active       display is in the active video region
//   col, row     display tile coordinate to read
//   tile         registered tile value for (col,row)
//   clear        single-cycle pulse: restart the full-memory clear
//   ready        clear finished, writes accepted
//   req0/req1    write request from requester 0 (game) / 1 (host)
//   x0/x1, y0/y1 write tile coordinates
//   d0/d1        write data
//   ack0/ack1    one-cycle grant, write commits on the granting edge
//   wr_err       granted write had out-of-range coordinates
interface tile_ram_arbiter_if #(
    parameter int COORD_W   = 6,
    parameter int TILE_BITS = 3
);
    logic                 active;
    logic [COORD_W-1:0]   col;
    logic [COORD_W-1:0]   row;
    logic [TILE_BITS-1:0] tile;
    logic                 clear;
    logic                 ready;
    logic                 req0;
    logic                 req1;
    logic [COORD_W-1:0]   x0;
    logic [COORD_W-1:0]   x1;
    logic [COORD_W-1:0]   y0;
    logic [COORD_W-1:0]   y1;
    logic [TILE_BITS-1:0] d0;
    logic [TILE_BITS-1:0] d1;
    logic                 ack0;
    logic                 ack1;
    logic                 wr_err;

    modport master (
        output active, col, row, clear, req0, req1, x0, x1, y0, y1, d0, d1,
        input  tile, ready, ack0, ack1, wr_err
    );

    modport slave (
        input  active, col, row, clear, req0, req1, x0, x1, y0, y1, d0, d1,
        output tile, ready, ack0, ack1, wr_err
    );
endinterface

// File: rtl/tile_ram_arbiter.sv
// rtl/tile_ram_arbiter.sv - tile RAM with blanking-only two-requester write arbitration and clear sequencer
//
// Ports:
//   i_Clk    system/pixel clock
//   i_Rst_n  asynchronous active-low reset
//   bus      tile_ram_arbiter_if.slave (display read port, clear control, two write requesters)
//
// Optional feature macro: TILE_ARB_FIXED_PRIO_EN
//   defined   - requester 0 always wins a collision, no round-robin pointer
//   undefined - round-robin between the two requesters
module tile_ram_arbiter #(
    parameter int GAME_WIDTH  = 40,
    parameter int GAME_HEIGHT = 30,
    parameter int COORD_W     = 6,
    parameter int TILE_BITS   = 3
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    tile_ram_arbiter_if.slave bus
);
    localparam int DEPTH = GAME_WIDTH * GAME_HEIGHT;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [COORD_W-1:0] W_C    = COORD_W'(GAME_WIDTH);
    localparam logic [COORD_W-1:0] H_C    = COORD_W'(GAME_HEIGHT);
    localparam logic [AW-1:0]      W_A    = AW'(GAME_WIDTH);
    localparam logic [AW-1:0]      LAST_A = AW'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t               state_q;
    logic [AW-1:0]        clr_addr_q;
    logic                 ready_q;
    logic                 ack0_q;
    logic                 ack1_q;
    logic                 wr_err_q;
    logic [TILE_BITS-1:0] tile_q;
`ifndef TILE_ARB_FIXED_PRIO_EN
    logic                 ptr_q;       // 0 = requester 0 wins the next collision
`endif

    logic [TILE_BITS-1:0] mem [DEPTH];

    logic                 run_ok;
    logic                 g0;
    logic                 g1;
    logic [COORD_W-1:0]   wx;
    logic [COORD_W-1:0]   wy;
    logic [TILE_BITS-1:0] wd;
    logic                 w_in;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [TILE_BITS-1:0] wdata;
    logic                 rd_in;
    logic [AW-1:0]        raddr;

    always_comb begin
        // Writes only in RUN, only during blanking, never in a clear-request cycle.
        run_ok = (state_q == ST_RUN) && !bus.active && !bus.clear;
        g0     = 1'b0;
        g1     = 1'b0;
`ifdef TILE_ARB_FIXED_PRIO_EN
        g0 = run_ok && bus.req0;
        g1 = run_ok && bus.req1 && !bus.req0;
`else
        if (bus.req0 && bus.req1) begin
            g0 = run_ok && !ptr_q;
            g1 = run_ok && ptr_q;
        end else begin
            g0 = run_ok && bus.req0;
            g1 = run_ok && bus.req1;
        end
`endif
        wx   = g1 ? bus.x1 : bus.x0;
        wy   = g1 ? bus.y1 : bus.y0;
        wd   = g1 ? bus.d1 : bus.d0;
        w_in = (wx < W_C) && (wy < H_C);

        if (state_q == ST_CLEAR) begin
            we    = 1'b1;
            waddr = clr_addr_q;
            wdata = '0;
        end else begin
            // Out-of-range grants are still acked but must not touch memory.
            we    = (g0 || g1) && w_in;
            waddr = AW'(wy) * W_A + AW'(wx);
            wdata = wd;
        end

        rd_in = (bus.col < W_C) && (bus.row < H_C);
        raddr = AW'(bus.row) * W_A + AW'(bus.col);
    end

    always_ff @(posedge i_Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            tile_q     <= '0;
`ifndef TILE_ARB_FIXED_PRIO_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            ack0_q   <= g0;
            ack1_q   <= g1;
            wr_err_q <= (g0 || g1) && !w_in;
            // Nonblocking read: a same-edge write to this address returns old data.
            tile_q   <= (ready_q && rd_in) ? mem[raddr] : '0;

            if (bus.clear) begin
                state_q    <= ST_CLEAR;
                clr_addr_q <= '0;
                ready_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_CLEAR: begin
                        if (clr_addr_q == LAST_A) begin
                            clr_addr_q <= '0;
                            ready_q    <= 1'b1;
                            state_q    <= ST_RUN;
                        end else begin
                            clr_addr_q <= clr_addr_q + 1'b1;
                        end
                    end
                    default: begin
`ifndef TILE_ARB_FIXED_PRIO_EN
                        // The pointer always moves away from whoever was just served.
                        if (g0) begin
                            ptr_q <= 1'b1;
                        end else if (g1) begin
                            ptr_q <= 1'b0;
                        end
`endif
                    end
                endcase
            end
        end
    end

    assign bus.tile   = tile_q;
    assign bus.ready  = ready_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.wr_err = wr_err_q;
endmodule

// File: tb/tb_tile_ram_arbiter.sv
// tb/tb_tile_ram_arbiter.sv - scoreboard bench for tile_ram_arbiter
module tb_tile_ram_arbiter;
    localparam int CW = 6;
    localparam int TB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_ram_arbiter_if #(.COORD_W(CW), .TILE_BITS(TB)) bus ();

    tile_ram_arbiter #(
        .GAME_WIDTH(40), .GAME_HEIGHT(30), .COORD_W(CW), .TILE_BITS(TB)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]    ack_q[$];   // expected {wr_err, ack1, ack0}
    logic [TB-1:0] rd_q[$];
    logic          rd_issue = 1'b0;
    logic          rd_d     = 1'b0;
    logic [2:0]    mon_code;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_d <= rd_issue;

    // Monitor: pops the scoreboard whenever the DUT presents an ack or a read result.
    initial begin
        forever begin
            @(negedge clk);
            mon_code = {bus.wr_err, bus.ack1, bus.ack0};
            if (mon_code != 3'b000) begin
                if (ack_q.size() == 0) check("unexpected_ack", int'(mon_code), 0);
                else                   check("ack_code", int'(mon_code), int'(ack_q.pop_front()));
            end
            if (rd_d) begin
                if (rd_q.size() == 0) check("rd_queue", rd_q.size(), 1);
                else                  check("tile", int'(bus.tile), int'(rd_q.pop_front()));
            end
        end
    end

    task automatic rd(input int col, input int row, input int exp);
        bus.col  = CW'(col);
        bus.row  = CW'(row);
        rd_issue = 1'b1;
        rd_q.push_back(TB'(exp));
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic wait_ack(input int who, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if ((who == 0 && bus.ack0) || (who == 1 && bus.ack1)) break;
        end
        if (who == 0) bus.req0 = 1'b0;
        else          bus.req1 = 1'b0;
    endtask

    task automatic wr(input int who, input int x, input int y, input int d,
                      input logic [2:0] exp, output int lat);
        if (who == 0) begin
            bus.x0 = CW'(x); bus.y0 = CW'(y); bus.d0 = TB'(d); bus.req0 = 1'b1;
        end else begin
            bus.x1 = CW'(x); bus.y1 = CW'(y); bus.d1 = TB'(d); bus.req1 = 1'b1;
        end
        ack_q.push_back(exp);
        wait_ack(who, lat);
    endtask

    int lat;
    int cyc;
    int seen;
    int i0;
    int i1;
    int ax[2] = '{10, 11};
    int ad[2] = '{1, 2};
    int bx[2] = '{20, 21};
    int bd[2] = '{4, 5};

    initial begin
        bus.active = 1'b0; bus.col = '0; bus.row = '0; bus.clear = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.d0 = '0;
        bus.x1 = '0; bus.y1 = '0; bus.d1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", int'(bus.ready), 0);
        check("rst_tile", int'(bus.tile), 0);
        check("rst_acks", int'({bus.ack1, bus.ack0}), 0);
        check("rst_err", int'(bus.wr_err), 0);

        // 1: clear takes exactly 1200 cycles, memory then reads 0
        rst_n = 1'b1;
        cyc = 0;
        while (!bus.ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("clear_cycles", cyc, 1200);
        rd(0, 0, 0);
        rd(39, 29, 0);
        rd(0, 1, 0);
        rd(40, 0, 0);

        // 2: single write from requester 0, acked next cycle
        wr(0, 5, 7, 3, 3'b001, lat);
        check("wr0_latency", lat, 1);
        rd(5, 7, 3);
        rd(6, 7, 0);

        // 5: out-of-range write from requester 1 acks with error, no memory change
        wr(1, 40, 0, 7, 3'b110, lat);
        check("oor_latency", lat, 1);
        rd(0, 1, 0);
        rd(0, 0, 0);
        rd(5, 7, 3);

        // 3: both requesters colliding
`ifdef TILE_ARB_FIXED_PRIO_EN
        ack_q.push_back(3'b001); ack_q.push_back(3'b001);
        ack_q.push_back(3'b010); ack_q.push_back(3'b010);
`else
        ack_q.push_back(3'b001); ack_q.push_back(3'b010);
        ack_q.push_back(3'b001); ack_q.push_back(3'b010);
`endif
        i0 = 0; i1 = 0; cyc = 0;
        bus.x0 = CW'(ax[0]); bus.y0 = CW'(2); bus.d0 = TB'(ad[0]); bus.req0 = 1'b1;
        bus.x1 = CW'(bx[0]); bus.y1 = CW'(3); bus.d1 = TB'(bd[0]); bus.req1 = 1'b1;
        while ((i0 < 2 || i1 < 2) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.ack0) begin
                i0++;
                if (i0 < 2) begin bus.x0 = CW'(ax[i0]); bus.d0 = TB'(ad[i0]); end
                else bus.req0 = 1'b0;
            end
            if (bus.ack1) begin
                i1++;
                if (i1 < 2) begin bus.x1 = CW'(bx[i1]); bus.d1 = TB'(bd[i1]); end
                else bus.req1 = 1'b0;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("pair_cycles", cyc, 4);
        rd(10, 2, 1);
        rd(11, 2, 2);
        rd(20, 3, 4);
        rd(21, 3, 5);

        // 4: request during active video waits for blanking
        bus.active = 1'b1;
        bus.x0 = CW'(2); bus.y0 = CW'(0); bus.d0 = TB'(6); bus.req0 = 1'b1;
        ack_q.push_back(3'b001);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ack0) seen++;
        end
        check("ack_in_active", seen, 0);
        bus.active = 1'b0;
        wait_ack(0, lat);
        check("blank_latency", lat, 1);
        rd(2, 0, 6);

        // 6: clear command plus reset mid-clear
        wr(0, 1, 1, 5, 3'b001, lat);
        rd(1, 1, 5);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("ready_after_clear", int'(bus.ready), 0);
        bus.x1 = CW'(3); bus.y1 = CW'(3); bus.d1 = TB'(1); bus.req1 = 1'b1;
        repeat (300) @(negedge clk);
        check("ready_mid_clear", int'(bus.ready), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_in_reset", int'(bus.ready), 0);
        rst_n = 1'b1;
        cyc = 0;
        while (!bus.ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        bus.req1 = 1'b0;
        check("reclear_cycles", cyc, 1200);
        rd(1, 1, 0);
        rd(3, 3, 0);

        repeat (3) @(negedge clk);
        check("ack_q_empty", ack_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
